// File: rtl/inst_fetch_pkg.sv
// Shared definitions for the instruction-fetch stage: widths, reset polarity,
// fetch-state encodings, the default cache size and a PC increment helper.
package inst_fetch_pkg;

  localparam int unsigned AddrLen     = 32;
  localparam int unsigned InstLen     = 32;
  localparam logic [InstLen-1:0] ZeroWord = '0;
  localparam logic        ResetEnable = 1'b1;
  localparam int unsigned ICacheLines = 64;

  typedef enum logic [1:0] {
    IfLookup = 2'd0,
    IfFetch  = 2'd1,
    IfHold   = 2'd2
  } if_state_e;

  // Sequential PC; wraps modulo 2^32.
  function automatic logic [AddrLen-1:0] next_pc(input logic [AddrLen-1:0] pc);
    return pc + AddrLen'(4);
  endfunction

endpackage

// File: rtl/inst_fetch_icache.sv
// Direct-mapped, one-word-per-line instruction cache.
// Ports:
//   clk_i      clock, rising edge
//   rst_i      asynchronous active-high reset, clears all valid bits
//   rd_word_i  word address (byte address >> 2) of the lookup
//   hit_o      lookup hit (combinational)
//   rd_data_o  cached instruction for rd_word_i (combinational)
//   wr_en_i    fill strobe, written on the rising edge
//   wr_word_i  word address of the fill
//   wr_data_i  instruction to fill
module inst_fetch_icache
  import inst_fetch_pkg::*;
#(
  parameter int unsigned Lines = ICacheLines
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [AddrLen-3:0]   rd_word_i,
  output logic                 hit_o,
  output logic [InstLen-1:0]   rd_data_o,
  input  logic                 wr_en_i,
  input  logic [AddrLen-3:0]   wr_word_i,
  input  logic [InstLen-1:0]   wr_data_i
);

  localparam int unsigned IdxW = $clog2(Lines);
  localparam int unsigned TagW = AddrLen - 2 - IdxW;

  logic [Lines-1:0]   valid_q, valid_d;
  logic [TagW-1:0]    tag_q  [Lines];
  logic [InstLen-1:0] data_q [Lines];

  logic [IdxW-1:0] rd_idx, wr_idx;
  logic [TagW-1:0] rd_tag, wr_tag;

  assign rd_idx = rd_word_i[IdxW-1:0];
  assign rd_tag = rd_word_i[AddrLen-3:IdxW];
  assign wr_idx = wr_word_i[IdxW-1:0];
  assign wr_tag = wr_word_i[AddrLen-3:IdxW];

  assign hit_o     = valid_q[rd_idx] && (tag_q[rd_idx] == rd_tag);
  assign rd_data_o = data_q[rd_idx];

  always_comb begin
    valid_d = valid_q;
    if (wr_en_i) valid_d[wr_idx] = 1'b1;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i == ResetEnable) valid_q <= '0;
    else                      valid_q <= valid_d;
  end

  // Tag/data need no reset: they are qualified by valid_q.
  always_ff @(posedge clk_i) begin
    if (wr_en_i) begin
      tag_q[wr_idx]  <= wr_tag;
      data_q[wr_idx] <= wr_data_i;
    end
  end

endmodule

// File: rtl/inst_fetch.sv
// Instruction-fetch stage. Owns the PC, assembles 32-bit little-endian
// instructions from a byte-wide granted memory port and presents them to
// IF/ID under a valid/stall handshake; jump_flag redirects the PC.
// Optional feature macro: ICACHE_EN adds a direct-mapped instruction cache
// (ICACHE_LINES one-word lines) that returns hits in a single LOOKUP cycle.
// Ports:
//   clk, rst            clock (rising edge), async active-high reset
//   jump_flag/jump_addr redirect request and word-aligned target from ID
//   stall_i             IF/ID cannot accept this cycle
//   mem_gnt/mem_din     grant for mem_addr; byte for last cycle's granted address
//   mem_req/mem_addr    byte read request and address (combinational)
//   pc_o/inst_o         PC and instruction presented to IF/ID
//   inst_valid_o        pc_o/inst_o are valid
module inst_fetch
  import inst_fetch_pkg::*;
#(
  parameter int unsigned ICACHE_LINES = ICacheLines
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               jump_flag,
  input  logic [AddrLen-1:0] jump_addr,
  input  logic               stall_i,
  input  logic               mem_gnt,
  input  logic [7:0]         mem_din,
  output logic               mem_req,
  output logic [AddrLen-1:0] mem_addr,
  output logic [AddrLen-1:0] pc_o,
  output logic [InstLen-1:0] inst_o,
  output logic               inst_valid_o
);

  if ((ICACHE_LINES < 2) || ((ICACHE_LINES & (ICACHE_LINES - 1)) != 0)) begin : g_bad_lines
    $error("ICACHE_LINES must be a power of 2");
  end

`ifdef ICACHE_EN
  localparam if_state_e StartSt = IfLookup;
`else
  // Without a cache there is nothing to look up: go straight to FETCH.
  localparam if_state_e StartSt = IfFetch;
`endif

  if_state_e          state_q, state_d;
  logic [AddrLen-1:0] pc_q, pc_d;
  logic [2:0]         issue_q, issue_d;
  logic [2:0]         recv_q, recv_d;
  logic [2:0][7:0]    byte_buf_q, byte_buf_d;
  logic               drop_q, drop_d;
  logic               gnt_q, gnt_d;
  logic [AddrLen-1:0] pc_o_q, pc_o_d;
  logic [InstLen-1:0] inst_q, inst_d;
  logic               valid_q, valid_d;

  logic               cache_hit;
  logic [InstLen-1:0] cache_data;
  logic               capture;

  // mem_req is gated by rst so it reads 0 during reset in either build.
  assign mem_req  = (rst != ResetEnable) && (state_q == IfFetch) && (issue_q < 3'd4);
  assign mem_addr = pc_q + {29'd0, issue_q};

  // A byte is on mem_din whenever the previous cycle was granted; drop_q
  // marks it as belonging to a fetch abandoned by a jump.
  assign capture  = (state_q == IfFetch) && gnt_q && !drop_q;

  assign pc_o         = pc_o_q;
  assign inst_o       = inst_q;
  assign inst_valid_o = valid_q;

`ifdef ICACHE_EN
  logic fill_en;
  assign fill_en = capture && (recv_q == 3'd3);

  inst_fetch_icache #(
    .Lines (ICACHE_LINES)
  ) u_icache (
    .clk_i     (clk),
    .rst_i     (rst),
    .rd_word_i (pc_q[AddrLen-1:2]),
    .hit_o     (cache_hit),
    .rd_data_o (cache_data),
    .wr_en_i   (fill_en),
    .wr_word_i (pc_q[AddrLen-1:2]),
    .wr_data_i ({mem_din, byte_buf_q})
  );
`else
  assign cache_hit  = 1'b0;
  assign cache_data = ZeroWord;
`endif

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    issue_d    = issue_q;
    recv_d     = recv_q;
    byte_buf_d = byte_buf_q;
    drop_d     = 1'b0;
    gnt_d      = mem_req && mem_gnt;
    pc_o_d     = pc_o_q;
    inst_d     = inst_q;
    valid_d    = valid_q;

    unique case (state_q)
      IfLookup: begin
        if (cache_hit) begin
          inst_d  = cache_data;
          pc_o_d  = pc_q;
          valid_d = 1'b1;
          state_d = IfHold;
        end else begin
          issue_d = '0;
          recv_d  = '0;
          state_d = IfFetch;
        end
      end
      IfFetch: begin
        if (mem_req && mem_gnt) issue_d = issue_q + 3'd1;
        if (capture) begin
          if (recv_q == 3'd3) begin
            inst_d  = {mem_din, byte_buf_q};
            pc_o_d  = pc_q;
            valid_d = 1'b1;
            state_d = IfHold;
          end else begin
            byte_buf_d[recv_q[1:0]] = mem_din;
            recv_d                  = recv_q + 3'd1;
          end
        end
      end
      IfHold: begin
        if (!stall_i) begin
          pc_d    = next_pc(pc_q);
          valid_d = 1'b0;
          issue_d = '0;
          recv_d  = '0;
          state_d = StartSt;
        end
      end
      default: state_d = StartSt;
    endcase

    // Redirect overrides everything; the word presented now is squashed.
    if (jump_flag) begin
      pc_d    = jump_addr;
      valid_d = 1'b0;
      inst_d  = inst_q;
      pc_o_d  = pc_o_q;
      issue_d = '0;
      recv_d  = '0;
      state_d = StartSt;
      drop_d  = mem_req && mem_gnt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst == ResetEnable) begin
      state_q    <= StartSt;
      pc_q       <= '0;
      issue_q    <= '0;
      recv_q     <= '0;
      byte_buf_q <= '0;
      drop_q     <= 1'b0;
      gnt_q      <= 1'b0;
      pc_o_q     <= '0;
      inst_q     <= ZeroWord;
      valid_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      issue_q    <= issue_d;
      recv_q     <= recv_d;
      byte_buf_q <= byte_buf_d;
      drop_q     <= drop_d;
      gnt_q      <= gnt_d;
      pc_o_q     <= pc_o_d;
      inst_q     <= inst_d;
      valid_q    <= valid_d;
    end
  end

endmodule
